// File: rtl/pwm_cmd_sched_if.sv
// Command byte stream in, committed PWM duty values and packet status out.
// master drives the byte strobe and period pulse; slave is the scheduler.
interface pwm_cmd_sched_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       PERIOD_END;
    logic [7:0] DUTY0;
    logic [7:0] DUTY1;
    logic [7:0] DUTY2;
    logic [7:0] DUTY3;
    logic       BUSY;
    logic       PEND;
    logic       ACK;
    logic       ERR;

    modport master (
        output RX_DATA, RX_VALID, PERIOD_END,
        input  DUTY0, DUTY1, DUTY2, DUTY3, BUSY, PEND, ACK, ERR
    );

    modport slave (
        input  RX_DATA, RX_VALID, PERIOD_END,
        output DUTY0, DUTY1, DUTY2, DUTY3, BUSY, PEND, ACK, ERR
    );
endinterface

// File: rtl/pwm_cmd_sched.sv
// Parses A5/ADDR/DUTY/CSUM packets into shadow duties, committed to DUTYn at PERIOD_END.
// ACK/ERR one cycle after the CSUM byte (or timeout); duty commit on the PERIOD_END edge.
// No backpressure: every RX_VALID byte is consumed in the cycle it arrives.
module pwm_cmd_sched #(
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic           CLK,
    input  logic           RST_N,
    pwm_cmd_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    // Abort fires on the edge where the gap counter would reach TIMEOUT_CYC.
    localparam logic [11:0] GAP_LAST = 12'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [11:0] gap_q;
    logic        addr_bcast_q;
    logic [1:0]  addr_ch_q;
    logic        addr_bad_q;
    logic [7:0]  addr_byte_q;
    logic [7:0]  data_q;
    logic [7:0]  shadow_q [4];
    logic [7:0]  duty_q   [4];
    logic        pend_q;
    logic        ack_q;
    logic        err_q;

    logic        latch_addr;
    logic        latch_data;
    logic        pkt_ok;
    logic        pkt_bad;
    logic        timeout;

    always_comb begin
        state_d    = state_q;
        latch_addr = 1'b0;
        latch_data = 1'b0;
        pkt_ok     = 1'b0;
        pkt_bad    = 1'b0;
        timeout    = 1'b0;
        if (state_q != ST_IDLE && !bus.RX_VALID && gap_q == GAP_LAST) begin
            timeout = 1'b1;
            state_d = ST_IDLE;
        end else if (bus.RX_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.RX_DATA == HDR_BYTE) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    latch_addr = 1'b1;
                    state_d    = ST_DATA;
                end
                ST_DATA: begin
                    latch_data = 1'b1;
                    state_d    = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (!addr_bad_q && bus.RX_DATA == (addr_byte_q ^ data_q))
                        pkt_ok = 1'b1;
                    else
                        pkt_bad = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            addr_bcast_q <= 1'b0;
            addr_ch_q    <= '0;
            addr_bad_q   <= 1'b0;
            addr_byte_q  <= '0;
            data_q       <= '0;
            pend_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            ack_q   <= pkt_ok;
            err_q   <= pkt_bad | timeout;

            if (bus.RX_VALID || state_q == ST_IDLE || timeout)
                gap_q <= '0;
            else
                gap_q <= gap_q + 12'd1;

            if (latch_addr) begin
                addr_byte_q  <= bus.RX_DATA;
                addr_bcast_q <= bus.RX_DATA[7];
                addr_ch_q    <= bus.RX_DATA[1:0];
                addr_bad_q   <= |bus.RX_DATA[6:2];
            end
            if (latch_data) data_q <= bus.RX_DATA;

            // Commit reads the pre-write shadows; a same-cycle write stays pending.
            for (int i = 0; i < 4; i++) begin
                if (bus.PERIOD_END && pend_q) duty_q[i] <= shadow_q[i];
                if (pkt_ok && (addr_bcast_q || addr_ch_q == i[1:0])) shadow_q[i] <= data_q;
            end

            if (pkt_ok)
                pend_q <= 1'b1;
            else if (bus.PERIOD_END)
                pend_q <= 1'b0;
        end
    end

    assign bus.DUTY0 = duty_q[0];
    assign bus.DUTY1 = duty_q[1];
    assign bus.DUTY2 = duty_q[2];
    assign bus.DUTY3 = duty_q[3];
    assign bus.BUSY  = (state_q != ST_IDLE);
    assign bus.PEND  = pend_q;
    assign bus.ACK   = ack_q;
    assign bus.ERR   = err_q;

endmodule
